bcd_ascii_streamer: RTL and testbench
=====================================

// Module: bcd_ascii_streamer
// PURPOSE
//   Parametrised BCD-to-ASCII formatter. Accepts a DIGITS-wide packed BCD word over a
//   valid/ready handshake and emits it as a byte stream (one ASCII char per beat) to the UART/LCD path.
//   Optional leading-zero blanking and an invalid-digit flag are provided.
//   A parallel ASCII word is also produced for the existing command bus.
// PARAMETERS
//   DIGITS      4      number of BCD digits (>=1); bcd width = 4*DIGITS
//   BLANK_CHAR  8'h20  substitute for blanked leading zeros
//   TERM_CHAR   8'h0D  terminator byte (used only when BCD_TERM_EN is defined)
// PORTS
//   clk           in   1          system clock, rising edge
//   rst           in   1          asynchronous, active-high reset
//   in_valid      in   1          bcd/blank_lz valid
//   in_ready      out  1          block can accept a word
//   bcd           in   4*DIGITS   digit k = bcd[4k+3:4k]; digit 0 is least significant
//   blank_lz      in   1          1 = blank leading zeros for this word
//   out_valid     out  1          out_char valid
//   out_ready     in   1          sink accepts out_char
//   out_char      out  8          ASCII byte; most significant digit first
//   out_last      out  1          marks the final byte of the word
//   command       out  8*DIGITS   parallel ASCII; byte for digit 0 in top byte [8*DIGITS-1 -: 8]
//   bad_digit     out  1          a digit >9 was seen in the last accepted word
// BEHAVIOUR
//   - Reset: in_ready=0 while rst is high, then 1 from the first clk edge after release.
//     out_valid=0, out_char=0, out_last=0, command=0, bad_digit=0, FSM=IDLE.
//   - FSM states: IDLE -> SEND -> (TERM) -> IDLE.
//     - in_ready=1 only in IDLE.
//     - Accept occurs when in_valid && in_ready. The accept latches bcd and blank_lz and loads the
//       digit index with DIGITS-1.
//   - Mapping per digit d:
//     - d<=9 gives 8'h30+d.
//     - d>9 gives 8'h3F ('?') and bad_digit=1. bad_digit is sticky until the next accept, where it
//       is recomputed for the new word.
//   - command: updated on the accept edge with the mapped (unblanked) chars. It holds until the next accept.
//   - Latency and order: out_valid rises the cycle after accept.
//     - Bytes are sent digit DIGITS-1 down to digit 0.
//     - An index decrement happens only on an out_valid && out_ready beat.
//     - out_char, out_valid and out_last stay stable while out_valid && !out_ready.
//   - Blanking (blank_lz=1): every zero digit above the most significant nonzero digit becomes BLANK_CHAR.
//     - Digit 0 is always printed, so all-zero input yields blanks followed by "0".
//     - Invalid digits count as nonzero and stop blanking.
//     - Byte count is always DIGITS; blanked positions are still sent.
//   - out_last is set on the digit-0 beat. With BCD_TERM_EN it is set on the terminator beat instead.
//   - After the final handshake: FSM=IDLE, out_valid=0, and in_ready=1 on the next cycle.
//     - Gap between words is >=1 cycle.
//     - A word offered during SEND waits; there is no drop.
//   - Sustained throughput is 1 byte/cycle with out_ready held high.
//   - DIGITS=1: a single beat with out_last=1.
//   - rst mid-word aborts the word immediately. No partial bytes are sent after rst deasserts; the
//     next word starts fresh.
// CONFIGURATION
//   BCD_TERM_EN defined:
//     - After digit 0, the TERM state emits TERM_CHAR as one extra beat with out_last=1.
//     - A word is DIGITS+1 beats.
//   BCD_TERM_EN undefined:
//     - The TERM state is not compiled in.
//     - A word is exactly DIGITS beats, with out_last on digit 0.
// TESTING
//   1 DIGITS=4, bcd=16'h1159, blank_lz=0, out_ready=1 -> "1","1","5","9" (31,31,35,39) on 4
//     consecutive cycles starting 1 cycle after accept.
//     Also out_last on 8'h39 and command=32'h39353131.
//   2 bcd=16'h0042, blank_lz=1 -> 20,20,34,32.
//     Also bcd=16'h0000, blank_lz=1 -> 20,20,20,30.
//   3 bcd=16'h12A4 -> 31,32,3F,34 and bad_digit=1.
//     Next accept with 16'h0001 clears bad_digit.
//   4 Toggle out_ready 1-0-0-1 during a word -> out_char/out_valid held during stalls.
//     Also in_ready=0 until the last beat, and no byte lost or duplicated.
//   5 Assert rst during the 2nd beat -> out_valid=0 while rst is high and in_ready=0.
//     After release, in_ready=1 at the first clk edge with no stale beats; the new word streams correctly.
//   6 With BCD_TERM_EN, bcd=16'h0007 -> 30,30,30,37,0D.
//     Also out_last only on 0D; back-to-back words are separated by exactly 1 idle cycle.

Source files
------------

// File: rtl/bcd_ascii_streamer.sv
// BCD-to-ASCII streamer: one BCD word in over valid/ready, one ASCII byte out per beat, MSD first.
// Define BCD_TERM_EN to append TERM_CHAR as an extra final beat after digit 0.
module bcd_ascii_streamer #(
  parameter int          DIGITS     = 4,
  parameter logic [7:0]  BLANK_CHAR = 8'h20,
  parameter logic [7:0]  TERM_CHAR  = 8'h0D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic                  blank_lz,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_char,
  output logic                  out_last,
  output logic [8*DIGITS-1:0]   command,
  output logic                  bad_digit,
  output logic [1:0]            dbg_state_o
);

  localparam int BW = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
`ifdef BCD_TERM_EN
  localparam bit TERM_EN = 1'b1;
`else
  localparam bit TERM_EN = 1'b0;
`endif

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // a producer holds its payload stable while valid is high and ready is low.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
`ifdef BCD_TERM_EN
    , TERM = 2'd2
`endif
  } state_t;

  state_t              state_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                out_last_q;
  logic [7:0]          out_char_q;
  logic [8*DIGITS-1:0] command_q;
  logic                bad_q;
  logic [BW-1:0]       bcd_q;
  logic                blank_q;
  logic [IW-1:0]       idx_q;
  logic [IW-1:0]       idx_d;
  logic [8*DIGITS-1:0] cmd_d;
  logic                bad_d;

  function automatic logic [7:0] map_digit(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 | {4'h0, d}) : 8'h3F;
  endfunction

  // A position is blanked when it and every digit above it are zero; digit 0 never blanks.
  function automatic logic [7:0] disp_char(input logic [BW-1:0] w, input logic blank,
                                           input logic [IW-1:0] k);
    logic lz;
    lz = blank;
    for (int j = DIGITS - 1; j >= 0; j--) begin
      if (j >= int'(k) && w[4*j +: 4] != 4'd0) lz = 1'b0;
    end
    if (lz && k != '0) return BLANK_CHAR;
    return map_digit(w[4*int'(k) +: 4]);
  endfunction

  assign idx_d = idx_q - IW'(1);

  always_comb begin
    cmd_d = '0;
    bad_d = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      cmd_d[8*(DIGITS-k)-1 -: 8] = map_digit(bcd[4*k +: 4]);
      if (bcd[4*k +: 4] > 4'd9) bad_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_char_q  <= 8'h00;
      command_q   <= '0;
      bad_q       <= 1'b0;
      bcd_q       <= '0;
      blank_q     <= 1'b0;
      idx_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            bcd_q       <= bcd;
            blank_q     <= blank_lz;
            idx_q       <= IW'(DIGITS - 1);
            command_q   <= cmd_d;
            bad_q       <= bad_d;
            out_char_q  <= disp_char(bcd, blank_lz, IW'(DIGITS - 1));
            out_valid_q <= 1'b1;
            out_last_q  <= (DIGITS == 1) && !TERM_EN;
            in_ready_q  <= 1'b0;
            state_q     <= SEND;
          end else begin
            in_ready_q  <= 1'b1;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (idx_q == '0) begin
              out_char_q <= TERM_EN ? TERM_CHAR : out_char_q;
`ifdef BCD_TERM_EN
              out_last_q <= 1'b1;
              state_q    <= TERM;
`else
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= IDLE;
`endif
            end else begin
              idx_q      <= idx_d;
              out_char_q <= disp_char(bcd_q, blank_q, idx_d);
              out_last_q <= (idx_d == '0) && !TERM_EN;
            end
          end
        end
`ifdef BCD_TERM_EN
        TERM: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_char    = out_char_q;
  assign out_last    = out_last_q;
  assign command     = command_q;
  assign bad_digit   = bad_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bcd_ascii_streamer.sv
// Directed bench for bcd_ascii_streamer (DIGITS=4); outputs sampled on the falling edge.
module tb_bcd_ascii_streamer;
  localparam int DIGITS = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd;
  logic                blank_lz;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          out_char;
  logic                out_last;
  logic [8*DIGITS-1:0] command;
  logic                bad_digit;
  logic [1:0]          dbg_state;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  bcd_ascii_streamer #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bcd(bcd),
    .blank_lz(blank_lz), .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .out_last(out_last), .command(command), .bad_digit(bad_digit), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected byte stream for one word, most significant char in bits [31:24].
  task automatic push_word(input logic [31:0] chars);
    for (int i = 3; i >= 0; i--) exp_q.push_back(chars[8*i +: 8]);
`ifdef BCD_TERM_EN
    exp_q.push_back(8'h0D);
`endif
  endtask

  // Called at a falling edge; returns at the falling edge that shows the first beat.
  task automatic accept_word(input string tag, input logic [15:0] w, input logic bl);
    int n;
    bcd = w;
    blank_lz = bl;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Expects one beat per falling edge (out_ready high) then an idle, ready cycle.
  task automatic collect_word(input string tag);
    logic [7:0] e;
    int nb;
    nb = 0;
    while (exp_q.size() > 0) begin
      if (nb > 0) @(negedge clk);
      e = exp_q.pop_front();
      chk({tag, "_valid"}, out_valid, 1'b1);
      chk({tag, "_char"}, out_char, e);
      chk({tag, "_last"}, out_last, exp_q.size() == 0);
      chk({tag, "_busy"}, in_ready, 1'b0);
      nb++;
    end
    @(negedge clk);
    chk({tag, "_idle_valid"}, out_valid, 1'b0);
    chk({tag, "_idle_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    bcd = '0;
    blank_lz = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_char", out_char, 8'h00);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_command", command, 32'h0);
    chk("rst_bad", bad_digit, 1'b0);
    rst = 1'b0;
    #1 chk("rel_in_ready_low", in_ready, 1'b0);
    @(negedge clk);
    chk("rel_in_ready_high", in_ready, 1'b1);

    // Plain word, no blanking
    push_word(32'h31313539);
    accept_word("w1159", 16'h1159, 1'b0);
    chk("w1159_command", command, 32'h39353131);
    collect_word("w1159");

    // Leading-zero blanking, back to back
    push_word(32'h20203432);
    accept_word("w0042", 16'h0042, 1'b1);
    chk("w0042_command", command, 32'h32343030);
    collect_word("w0042");
    push_word(32'h20202030);
    accept_word("w0000", 16'h0000, 1'b1);
    chk("w0000_command", command, 32'h30303030);
    collect_word("w0000");

    // Invalid digit, then cleared on next accept
    push_word(32'h31323F34);
    accept_word("w12a4", 16'h12A4, 1'b0);
    chk("w12a4_bad", bad_digit, 1'b1);
    chk("w12a4_command", command, 32'h343F3231);
    collect_word("w12a4");
    chk("w12a4_bad_sticky", bad_digit, 1'b1);
    push_word(32'h30303031);
    accept_word("w0001", 16'h0001, 1'b0);
    chk("w0001_bad", bad_digit, 1'b0);
    collect_word("w0001");

    // Backpressure 1-0-0-1 on the second beat
    push_word(32'h33383137);
    accept_word("stall", 16'h3817, 1'b0);
    chk("stall_b0", out_char, exp_q.pop_front());
    @(negedge clk);
    chk("stall_b1_char", out_char, exp_q[0]);
    out_ready = 1'b0;
    @(negedge clk);
    chk("stall_hold1_char", out_char, exp_q[0]);
    chk("stall_hold1_valid", out_valid, 1'b1);
    chk("stall_hold1_last", out_last, 1'b0);
    chk("stall_hold1_ready", in_ready, 1'b0);
    @(negedge clk);
    chk("stall_hold2_char", out_char, exp_q[0]);
    chk("stall_hold2_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    collect_word("stall");

    // Reset in the middle of a word
    push_word(32'h35363738);
    accept_word("rstw", 16'h5678, 1'b0);
    chk("rstw_b0", out_char, 8'h35);
    @(negedge clk);
    chk("rstw_b1", out_char, 8'h36);
    rst = 1'b1;
    #1;
    chk("rstw_valid_async", out_valid, 1'b0);
    chk("rstw_ready_async", in_ready, 1'b0);
    @(negedge clk);
    chk("rstw_valid_held", out_valid, 1'b0);
    chk("rstw_ready_held", in_ready, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rstw_ready_after", in_ready, 1'b1);
    chk("rstw_valid_after", out_valid, 1'b0);
    chk("rstw_command_after", command, 32'h0);
    push_word(32'h20333035);
    accept_word("w0305", 16'h0305, 1'b1);
    collect_word("w0305");

    // Zeros above a single digit, no blanking
    push_word(32'h30303037);
    accept_word("w0007", 16'h0007, 1'b0);
    collect_word("w0007");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
